// File: rtl/sun_tracker.sv
// sun_tracker: two-axis lux-balancing tracker that issues rate-limited stepper pulses with soft travel limits
module sun_tracker #(
  parameter logic [15:0] DEADBAND = 16'd64,
  parameter int STEP_DIV = 50000,
  parameter int SETTLE_CYCLES = 1000000,
  parameter logic [11:0] POS_MAX = 12'd2000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic [15:0] n_lux,
  input  logic [15:0] e_lux,
  input  logic [15:0] s_lux,
  input  logic [15:0] w_lux,
  output logic        az_step,
  output logic        az_dir,
  output logic        el_step,
  output logic        el_dir,
  output logic [11:0] az_pos,
  output logic [11:0] el_pos,
  output logic        az_limit,
  output logic        el_limit,
  output logic        busy
);
  typedef enum logic [2:0] {IDLE, EVAL, STEP_AZ, STEP_EL, SETTLE} state_t;
  localparam logic [31:0] STEP_LAST = 32'(STEP_DIV - 1);
  localparam logic [31:0] STEP_PRE = 32'(STEP_DIV - 2);
  localparam logic [31:0] SETTLE_LAST = 32'(SETTLE_CYCLES - 1);
  localparam logic [11:0] HOME = POS_MAX >> 1;
  state_t state_q, state_d;
  logic [31:0] cnt_q, cnt_d;
  logic az_step_q, az_step_d, el_step_q, el_step_d, az_dir_q, az_dir_d, el_dir_q, el_dir_d;
  logic az_limit_q, az_limit_d, el_limit_q, el_limit_d, busy_q, busy_d;
  logic [11:0] az_pos_q, az_pos_d, el_pos_q, el_pos_d;
  logic [16:0] d_ew, d_ns;
  logic [15:0] ew_mag, ns_mag;
  logic az_want, el_want, az_east, el_north, az_blk, el_blk, az_go, el_go;
  assign d_ew = {1'b0, e_lux} - {1'b0, w_lux};
  assign d_ns = {1'b0, n_lux} - {1'b0, s_lux};
  assign ew_mag = d_ew[16] ? 16'(~d_ew + 17'd1) : d_ew[15:0];
  assign ns_mag = d_ns[16] ? 16'(~d_ns + 17'd1) : d_ns[15:0];
  assign az_want = ew_mag > DEADBAND;
  assign el_want = ns_mag > DEADBAND;
  assign az_east = ~d_ew[16];
  assign el_north = ~d_ns[16];
  assign az_blk = az_east ? az_pos_q == POS_MAX : az_pos_q == 12'd0;
  assign el_blk = el_north ? el_pos_q == POS_MAX : el_pos_q == 12'd0;
  assign az_go = az_want & ~az_blk;
  assign el_go = el_want & ~el_blk;
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q + 32'd1;
    az_step_d = 1'b0;
    el_step_d = 1'b0;
    az_dir_d = az_dir_q;
    el_dir_d = el_dir_q;
    az_pos_d = az_pos_q;
    el_pos_d = el_pos_q;
    az_limit_d = az_limit_q;
    el_limit_d = el_limit_q;
    case (state_q)
      IDLE: begin
        cnt_d = 32'd0;
        if (enable) state_d = EVAL;
      end
      EVAL: begin
        cnt_d = 32'd0;
        if (!enable) state_d = IDLE;
        else begin
          az_limit_d = az_want & az_blk;
          el_limit_d = el_want & el_blk;
          state_d = az_go ? STEP_AZ : el_go ? STEP_EL : SETTLE;
          if (az_go) az_dir_d = az_east;
          else if (el_go) el_dir_d = el_north;
        end
      end
      STEP_AZ: begin
        // pulse is registered one cycle early so it lands in the final step cycle
        az_step_d = cnt_q == STEP_PRE;
        if (cnt_q == STEP_LAST) begin
          cnt_d = 32'd0;
          state_d = SETTLE;
          az_pos_d = az_dir_q ? az_pos_q + 12'd1 : az_pos_q - 12'd1;
        end
      end
      STEP_EL: begin
        el_step_d = cnt_q == STEP_PRE;
        if (cnt_q == STEP_LAST) begin
          cnt_d = 32'd0;
          state_d = SETTLE;
          el_pos_d = el_dir_q ? el_pos_q + 12'd1 : el_pos_q - 12'd1;
        end
      end
      SETTLE: begin
        if (cnt_q == SETTLE_LAST) begin
          cnt_d = 32'd0;
          state_d = EVAL;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = state_d != IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q <= 32'd0;
      az_step_q <= 1'b0;
      el_step_q <= 1'b0;
      az_dir_q <= 1'b0;
      el_dir_q <= 1'b0;
      az_pos_q <= HOME;
      el_pos_q <= HOME;
      az_limit_q <= 1'b0;
      el_limit_q <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      az_step_q <= az_step_d;
      el_step_q <= el_step_d;
      az_dir_q <= az_dir_d;
      el_dir_q <= el_dir_d;
      az_pos_q <= az_pos_d;
      el_pos_q <= el_pos_d;
      az_limit_q <= az_limit_d;
      el_limit_q <= el_limit_d;
      busy_q <= busy_d;
    end
  end
  assign az_step = az_step_q;
  assign el_step = el_step_q;
  assign az_dir = az_dir_q;
  assign el_dir = el_dir_q;
  assign az_pos = az_pos_q;
  assign el_pos = el_pos_q;
  assign az_limit = az_limit_q;
  assign el_limit = el_limit_q;
  assign busy = busy_q;
endmodule

// File: tb/tb_sun_tracker.sv
// tb_sun_tracker: directed scenario tests for sun_tracker with small parameters
module tb_sun_tracker;
  logic clk = 0, rst = 1, enable = 0;
  logic [15:0] n_lux = 0, e_lux = 0, s_lux = 0, w_lux = 0;
  logic az_step, az_dir, el_step, el_dir, az_limit, el_limit, busy;
  logic [11:0] az_pos, el_pos;
  int pass = 0, total = 0, cyc = 0;
  int az_cnt, el_cnt, az_wide, el_wide, az_gap_bad, el_gap_bad, first_az, last_az, first_el, last_el, t_en;
  logic az_prev = 0, el_prev = 0;
  sun_tracker #(.DEADBAND(16'd10), .STEP_DIV(4), .SETTLE_CYCLES(8), .POS_MAX(12'd15)) dut (
    .clk(clk), .rst(rst), .enable(enable), .n_lux(n_lux), .e_lux(e_lux), .s_lux(s_lux), .w_lux(w_lux),
    .az_step(az_step), .az_dir(az_dir), .el_step(el_step), .el_dir(el_dir), .az_pos(az_pos), .el_pos(el_pos),
    .az_limit(az_limit), .el_limit(el_limit), .busy(busy));
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  always @(negedge clk) begin
    if (az_step) begin
      if (az_prev) az_wide++;
      else begin
        if (az_cnt > 0 && cyc - last_az != 13) az_gap_bad++;
        if (az_cnt == 0) first_az = cyc;
        last_az = cyc;
        az_cnt++;
      end
    end
    if (el_step) begin
      if (el_prev) el_wide++;
      else begin
        if (el_cnt > 0 && cyc - last_el != 13) el_gap_bad++;
        if (el_cnt == 0) first_el = cyc;
        last_el = cyc;
        el_cnt++;
      end
    end
    az_prev = az_step;
    el_prev = el_step;
  end
  task automatic do_reset(input logic [15:0] n, e, s, w);
    rst = 1; enable = 0;
    n_lux = n; e_lux = e; s_lux = s; w_lux = w;
    repeat (3) @(negedge clk);
    rst = 0;
    az_cnt = 0; el_cnt = 0; az_wide = 0; el_wide = 0; az_gap_bad = 0; el_gap_bad = 0;
  endtask
  task automatic start;
    enable = 1;
    t_en = cyc;
  endtask
  task automatic test_reset;
    do_reset(0, 0, 0, 0);
    total++; if (az_pos !== 12'd7) $display("FAIL reset_az_pos got %0d want 7", az_pos); else pass++;
    total++; if (el_pos !== 12'd7) $display("FAIL reset_el_pos got %0d want 7", el_pos); else pass++;
    total++; if ({busy, az_step, el_step, az_dir, el_dir, az_limit, el_limit} !== 7'b0)
      $display("FAIL reset_flags got %b want 0000000", {busy, az_step, el_step, az_dir, el_dir, az_limit, el_limit}); else pass++;
    repeat (100) @(negedge clk);
    total++; if (az_cnt + el_cnt !== 0) $display("FAIL idle_pulses got %0d want 0", az_cnt + el_cnt); else pass++;
    total++; if (busy !== 1'b0) $display("FAIL idle_busy got %b want 0", busy); else pass++;
  endtask
  task automatic test_east;
    do_reset(0, 100, 0, 50);
    start();
    repeat (120) @(negedge clk);
    total++; if (az_cnt !== 8) $display("FAIL east_count got %0d want 8", az_cnt); else pass++;
    total++; if (first_az - t_en !== 5) $display("FAIL east_first got %0d want 5", first_az - t_en); else pass++;
    total++; if (az_gap_bad !== 0) $display("FAIL east_gap got %0d want 0", az_gap_bad); else pass++;
    total++; if (az_wide !== 0) $display("FAIL east_width got %0d want 0", az_wide); else pass++;
    total++; if (az_pos !== 12'd15) $display("FAIL east_pos got %0d want 15", az_pos); else pass++;
    total++; if (az_dir !== 1'b1) $display("FAIL east_dir got %b want 1", az_dir); else pass++;
    total++; if (az_limit !== 1'b1) $display("FAIL east_limit got %b want 1", az_limit); else pass++;
    total++; if (el_cnt !== 0 || el_limit !== 1'b0) $display("FAIL east_el got cnt=%0d lim=%b want 0/0", el_cnt, el_limit); else pass++;
    repeat (40) @(negedge clk);
    total++; if (az_cnt !== 8) $display("FAIL east_held got %0d want 8", az_cnt); else pass++;
  endtask
  task automatic test_deadband;
    do_reset(0, 60, 0, 50);
    start();
    repeat (40) @(negedge clk);
    total++; if (az_cnt !== 0) $display("FAIL db_equal_count got %0d want 0", az_cnt); else pass++;
    total++; if (az_limit !== 1'b0) $display("FAIL db_limit got %b want 0", az_limit); else pass++;
    total++; if (busy !== 1'b1) $display("FAIL db_busy got %b want 1", busy); else pass++;
    e_lux = 61;
    repeat (16) @(negedge clk);
    total++; if (az_cnt !== 1) $display("FAIL db_over_count got %0d want 1", az_cnt); else pass++;
    total++; if (az_dir !== 1'b1) $display("FAIL db_over_dir got %b want 1", az_dir); else pass++;
    total++; if (az_pos !== 12'd8) $display("FAIL db_over_pos got %0d want 8", az_pos); else pass++;
  endtask
  task automatic test_priority;
    do_reset(0, 100, 100, 0);
    start();
    repeat (220) @(negedge clk);
    total++; if (az_cnt !== 8) $display("FAIL prio_az_count got %0d want 8", az_cnt); else pass++;
    total++; if (el_cnt !== 7) $display("FAIL prio_el_count got %0d want 7", el_cnt); else pass++;
    total++; if (first_el <= last_az) $display("FAIL prio_order got first_el=%0d last_az=%0d want first_el later", first_el, last_az); else pass++;
    total++; if (az_pos !== 12'd15 || el_pos !== 12'd0) $display("FAIL prio_pos got az=%0d el=%0d want 15/0", az_pos, el_pos); else pass++;
    total++; if (az_dir !== 1'b1 || el_dir !== 1'b0) $display("FAIL prio_dir got az=%b el=%b want 1/0", az_dir, el_dir); else pass++;
    total++; if (az_limit !== 1'b1 || el_limit !== 1'b1) $display("FAIL prio_limit got az=%b el=%b want 1/1", az_limit, el_limit); else pass++;
    total++; if (el_gap_bad !== 0 || el_wide !== 0) $display("FAIL prio_el_timing got gap=%0d wide=%0d want 0/0", el_gap_bad, el_wide); else pass++;
  endtask
  task automatic test_west;
    do_reset(0, 0, 0, 200);
    start();
    repeat (110) @(negedge clk);
    total++; if (az_cnt !== 7) $display("FAIL west_count got %0d want 7", az_cnt); else pass++;
    total++; if (az_pos !== 12'd0) $display("FAIL west_pos got %0d want 0", az_pos); else pass++;
    total++; if (az_dir !== 1'b0) $display("FAIL west_dir got %b want 0", az_dir); else pass++;
    total++; if (az_limit !== 1'b1) $display("FAIL west_limit got %b want 1", az_limit); else pass++;
  endtask
  task automatic test_reset_abort;
    do_reset(0, 100, 0, 50);
    start();
    repeat (4) @(negedge clk);
    rst = 1;
    @(negedge clk);
    total++; if (az_step !== 1'b0 || busy !== 1'b0) $display("FAIL abort_out got step=%b busy=%b want 0/0", az_step, busy); else pass++;
    total++; if (az_pos !== 12'd7) $display("FAIL abort_pos got %0d want 7", az_pos); else pass++;
    rst = 0; enable = 0;
    repeat (20) @(negedge clk);
    total++; if (az_cnt !== 0 || busy !== 1'b0) $display("FAIL abort_idle got cnt=%0d busy=%b want 0/0", az_cnt, busy); else pass++;
    start();
    repeat (8) @(negedge clk);
    enable = 0;
    repeat (32) @(negedge clk);
    total++; if (az_cnt !== 1) $display("FAIL settle_drop_count got %0d want 1", az_cnt); else pass++;
    total++; if (busy !== 1'b0) $display("FAIL settle_drop_busy got %b want 0", busy); else pass++;
    total++; if (az_pos !== 12'd8) $display("FAIL settle_drop_pos got %0d want 8", az_pos); else pass++;
  endtask
  task automatic test_equal_extremes;
    do_reset(16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF);
    start();
    repeat (30) @(negedge clk);
    total++; if (az_cnt + el_cnt !== 0) $display("FAIL equal_ffff got %0d want 0", az_cnt + el_cnt); else pass++;
    e_lux = 16'hFFFF; w_lux = 16'h0000; n_lux = 16'h0000; s_lux = 16'hFFFF;
    repeat (20) @(negedge clk);
    total++; if (az_cnt !== 1 || az_dir !== 1'b1) $display("FAIL extreme_ew got cnt=%0d dir=%b want 1/1", az_cnt, az_dir); else pass++;
  endtask
  initial begin
    test_reset();
    test_east();
    test_deadband();
    test_priority();
    test_west();
    test_reset_abort();
    test_equal_extremes();
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule

// File: doc/sun_tracker.md
Name: sun_tracker

Overview:
- Two-axis solar-panel tracker. Sits directly downstream of the I2C sensor-polling controller and consumes its latched n_lux/e_lux/s_lux/w_lux outputs.
- Balances east/west light to drive the azimuth stepper and north/south light to drive the elevation stepper.
- Issues rate-limited single-step pulses, tracks the position of each axis, and enforces soft travel limits.
- Waits a settle interval after each decision so that fresh lux readings arrive before the next evaluation.

Parameters:
DEADBAND, 16'd64, minimum |lux difference| that causes a step; the comparison is strict (>)
STEP_DIV, 50000, number of cycles in a STEP state (step-pulse spacing); must be ≥2
SETTLE_CYCLES, 1000000, number of cycles in the SETTLE state; must be ≥1
POS_MAX, 12'd2000, upper soft limit of each axis position; the lower limit is 0

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
enable  in  1  tracking enable
n_lux  in  16  north lux (unsigned)
e_lux  in  16  east lux
s_lux  in  16  south lux
w_lux  in  16  west lux
az_step  out  1  azimuth step pulse, exactly 1 cycle wide
az_dir  out  1  azimuth direction: 1 = toward east, 0 = toward west
el_step  out  1  elevation step pulse, exactly 1 cycle wide
el_dir  out  1  elevation direction: 1 = toward north, 0 = toward south
az_pos  out  12  azimuth position
el_pos  out  12  elevation position
az_limit  out  1  azimuth blocked at a limit in the last EVAL
el_limit  out  1  elevation blocked at a limit in the last EVAL
busy  out  1  high in any state other than IDLE

Behaviour:
- One clock (clk). Reset is synchronous and active-high (rst). All outputs are registered.
- Reset values:
  - state = IDLE
  - az_step = el_step = 0, az_dir = el_dir = 0
  - az_pos = el_pos = POS_MAX>>1
  - az_limit = el_limit = 0, busy = 0
  - all counters = 0
- Reset asserted mid-operation aborts immediately. No step pulse is emitted and positions return to POS_MAX>>1.
- States: IDLE, EVAL, STEP_AZ, STEP_EL, SETTLE.
- IDLE:
  - enable=1 → EVAL on the next cycle.
  - Otherwise remain in IDLE.
- EVAL (exactly 1 cycle):
  - If enable=0 → IDLE.
  - Otherwise sample all four lux inputs in this cycle.
  - Compute d_ew = e_lux − w_lux and d_ns = n_lux − s_lux as 17-bit signed values; magnitudes are 16-bit unsigned.
  - Azimuth move wanted: |d_ew| > DEADBAND. Direction is east if d_ew > 0.
  - Elevation move wanted: |d_ns| > DEADBAND. Direction is north if d_ns > 0.
  - A wanted move is blocked if it would exceed a limit: az_pos==POS_MAX toward east, or az_pos==0 toward west; elevation likewise.
  - Set az_limit/el_limit = 1 if that axis's move is wanted but blocked; otherwise 0. The flags update on every EVAL.
  - Priority: an unblocked azimuth move → STEP_AZ. Else an unblocked elevation move → STEP_EL. Else → SETTLE.
  - Only one axis steps per evaluation. Elevation therefore steps only once azimuth is balanced or blocked.
  - The dir output for the chosen axis is registered at the EVAL→STEP transition and held until the next EVAL that chooses that axis.
  - This guarantees ≥ STEP_DIV−1 cycles of dir setup before the step pulse.
- STEP_AZ / STEP_EL:
  - The state lasts exactly STEP_DIV cycles (cycle counter 0..STEP_DIV−1).
  - The step output is high only in the last cycle.
  - The position is updated ±1 on the clock edge that ends the state.
  - Next state → SETTLE.
  - enable is ignored in this state; a started step always completes.
- SETTLE:
  - The state lasts exactly SETTLE_CYCLES cycles, then → EVAL.
  - enable=0 is honoured at the following EVAL.
- Loop period while stepping: 1 + STEP_DIV + SETTLE_CYCLES cycles. When no move is made: 1 + SETTLE_CYCLES.
- Positions saturate within 0..POS_MAX. Limits are checked before stepping, so positions never wrap.
- Lux inputs may change on any cycle. Only the values present in the EVAL cycle matter.
- Equal inputs, including all-zero and both 16'hFFFF → no move.

Test Plan:
(Bench parameters: DEADBAND=10, STEP_DIV=4, SETTLE_CYCLES=8, POS_MAX=15.)
- Reset then idle, enable=0 → az_pos=el_pos=7, busy=0, no step pulses for 100 cycles.
- enable=1, e=100, w=50, n=s=0:
  - az_dir=1.
  - A 1-cycle az_step occurs every 13 cycles; the first is 5 cycles after EVAL.
  - az_pos goes 7→8→…→15.
  - Then az_limit=1 and no further az_step pulses.
- Deadband boundary, e=60, w=50 (diff = DEADBAND) → no step, az_limit=0. Change to e=61 → az_dir=1 and a step at the next evaluation.
- Priority, e=100, w=0, n=0, s=100 → only az steps (az_dir=1) until az_pos=15. After that each loop produces el_step with el_dir=0, and el_pos decrements to 0 then el_limit=1.
- Direction/west, w=200, e=0 from reset → az_dir=0, az_pos 7→0, then az_limit=1.
- Reset asserted in the cycle before az_step would pulse → az_step never goes high, az_pos=7, state IDLE, busy=0. Deassert enable during SETTLE → the next EVAL goes to IDLE with no further pulses.
